cin_auto_align: RTL and testbench

- Hardware training engine that replaces the software-driven per-bit IDELAY eye scan and bitslip sequence on parallel serial-control inputs, one or more channels.
- For each enabled channel in turn it sweeps the IDELAY taps, measures bit errors at each tap, loads the centre of the widest error-free window, then bitslips until the captured parallel word matches the training word.
- Sits in the sysclk domain next to the ISERDES/IDELAY front ends and the training-pattern checkers; the register core only starts it and reads back the results.

---
 rtl/cin_auto_align.sv | 191 +++++++++++++++++++
 tb/tb_cin_auto_align.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cin_auto_align.sv
// Hardware IDELAY eye-scan and bitslip training engine.
// Channels are trained one at a time: sweep taps, centre on the widest clean window, then slip to the training word.
module cin_auto_align #(
   parameter int                    NCHAN         = 1,
   parameter int                    TAP_BITS      = 5,
   parameter int                    DATA_WIDTH    = 4,
   parameter logic [DATA_WIDTH-1:0] TRAIN_WORD    = DATA_WIDTH'(4'h6),
   parameter int                    SETTLE_CYCLES = 16,
   parameter int                    DWELL_CYCLES  = 1024,
   parameter int                    MIN_EYE       = 4
) (
   input  logic                          sysclk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [NCHAN-1:0]              chan_mask_i,
   input  logic [NCHAN-1:0]              biterr_i,
   input  logic [NCHAN*DATA_WIDTH-1:0]   data_i,
   output logic [NCHAN-1:0]              idelay_load_o,
   output logic [TAP_BITS-1:0]           idelay_value_o,
   output logic [NCHAN-1:0]              bitslip_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [NCHAN-1:0]              fail_o,
   output logic [NCHAN*TAP_BITS-1:0]     eye_center_o,
   output logic [NCHAN*(TAP_BITS+1)-1:0] eye_width_o
);

   localparam int CH_W    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SLIP_W  = $clog2(DATA_WIDTH + 1);
   localparam int LEN_W   = TAP_BITS + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_SELECT, S_LOAD, S_SETTLE, S_DWELL, S_EVAL,
      S_CENTER, S_CHECK, S_SLIP, S_NEXT, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [CH_W-1:0]     ch;
   logic [NCHAN-1:0]    mask_q;
   logic [TAP_BITS-1:0] tap;
   logic [TAP_BITS-1:0] run_start, best_start;
   logic [LEN_W-1:0]    run_len, best_len;
   logic                err;
   logic [CNT_W-1:0]    cnt;
   logic [SLIP_W-1:0]   slips;
   logic                checking;   // settle leads to CHECK rather than DWELL

   logic [NCHAN-1:0]    fail_q;
   logic [NCHAN*TAP_BITS-1:0] center_q;
   logic [NCHAN*LEN_W-1:0]    width_q;

   logic [NCHAN-1:0]    ch_sel;
   logic [LEN_W-1:0]    run_len_inc;
   logic [TAP_BITS-1:0] center;
   logic                word_match;
   logic                settle_last, dwell_last, tap_last;

   assign ch_sel      = NCHAN'(1) << ch;
   assign run_len_inc = run_len + LEN_W'(1);
   assign center      = best_start + TAP_BITS'(best_len >> 1);
   assign word_match  = (data_i[ch*DATA_WIDTH +: DATA_WIDTH] == TRAIN_WORD);
   assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign dwell_last  = (cnt == CNT_W'(DWELL_CYCLES - 1));
   assign tap_last    = (tap == {TAP_BITS{1'b1}});

   assign fail_o       = fail_q;
   assign eye_center_o = center_q;
   assign eye_width_o  = width_q;

   // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      idelay_load_o  = '0;
      idelay_value_o = '0;
      bitslip_o      = '0;
      busy_o         = (state != S_IDLE) && (state != S_DONE);
      done_o         = (state == S_DONE);
      case (state)
         S_IDLE:   if (start_i) state_nxt = S_SELECT;
         S_SELECT: state_nxt = mask_q[ch] ? S_LOAD : S_NEXT;
         S_LOAD: begin
            idelay_load_o  = ch_sel;
            idelay_value_o = tap;
            state_nxt      = S_SETTLE;
         end
         S_SETTLE: if (settle_last) state_nxt = checking ? S_CHECK : S_DWELL;
         S_DWELL:  if (dwell_last) state_nxt = S_EVAL;
         S_EVAL:   state_nxt = tap_last ? S_CENTER : S_LOAD;
         S_CENTER: state_nxt = (best_len < LEN_W'(MIN_EYE)) ? S_NEXT : S_LOAD;
         S_CHECK: begin
            if (word_match || slips == SLIP_W'(DATA_WIDTH)) state_nxt = S_NEXT;
            else                                             state_nxt = S_SLIP;
         end
         S_SLIP: begin
            bitslip_o = ch_sel;
            state_nxt = S_SETTLE;
         end
         S_NEXT:  state_nxt = (ch == CH_W'(NCHAN - 1)) ? S_DONE : S_SELECT;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         ch         <= '0;
         mask_q     <= '0;
         tap        <= '0;
         run_start  <= '0;
         run_len    <= '0;
         best_start <= '0;
         best_len   <= '0;
         err        <= 1'b0;
         cnt        <= '0;
         slips      <= '0;
         checking   <= 1'b0;
         fail_q     <= '0;
         center_q   <= '0;
         width_q    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  mask_q   <= chan_mask_i;
                  fail_q   <= '0;
                  center_q <= '0;
                  width_q  <= '0;
                  ch       <= '0;
               end
            end
            S_SELECT: begin
               tap        <= '0;
               run_start  <= '0;
               run_len    <= '0;
               best_start <= '0;
               best_len   <= '0;
               slips      <= '0;
               checking   <= 1'b0;
            end
            S_LOAD: begin
               cnt <= '0;
               err <= 1'b0;
            end
            S_SETTLE: cnt <= settle_last ? '0 : cnt + CNT_W'(1);
            S_DWELL: begin
               err <= err | biterr_i[ch];
               cnt <= cnt + CNT_W'(1);
            end
            S_EVAL: begin
               if (!err) begin
                  if (run_len == '0) run_start <= tap;
                  run_len <= run_len_inc;
                  // Strictly greater: the lowest of equal-width windows is kept.
                  if (run_len_inc > best_len) begin
                     best_start <= (run_len == '0) ? tap : run_start;
                     best_len   <= run_len_inc;
                  end
               end else begin
                  run_len <= '0;
               end
               if (!tap_last) tap <= tap + TAP_BITS'(1);
            end
            S_CENTER: begin
               center_q[ch*TAP_BITS +: TAP_BITS] <= center;
               width_q[ch*LEN_W +: LEN_W]        <= best_len;
               if (best_len < LEN_W'(MIN_EYE)) begin
                  fail_q[ch] <= 1'b1;
               end else begin
                  tap      <= center;
                  checking <= 1'b1;
               end
            end
            S_CHECK: begin
               if (!word_match) begin
                  if (slips == SLIP_W'(DATA_WIDTH)) fail_q[ch] <= 1'b1;
                  else                              slips <= slips + SLIP_W'(1);
               end
            end
            S_SLIP: cnt <= '0;
            S_NEXT: if (ch != CH_W'(NCHAN - 1)) ch <= ch + CH_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cin_auto_align.sv
// Directed bench for cin_auto_align: a small ISERDES/IDELAY front-end model driven by the DUT strobes.
// Expected results are hand-computed from the chosen eye maps and word rotations.
module tb_cin_auto_align;

   localparam int NCHAN = 3;
   localparam int TB    = 5;
   localparam int DW    = 4;

   logic               sysclk = 1'b0;
   logic               rst, start;
   logic [NCHAN-1:0]   chan_mask, biterr;
   logic [NCHAN*DW-1:0] data;
   logic [NCHAN-1:0]   idelay_load, bitslip, fail;
   logic [TB-1:0]      idelay_value;
   logic               busy, done;
   logic [NCHAN*TB-1:0]     eye_center;
   logic [NCHAN*(TB+1)-1:0] eye_width;

   cin_auto_align #(
      .NCHAN(NCHAN), .TAP_BITS(TB), .DATA_WIDTH(DW), .TRAIN_WORD(4'h6),
      .SETTLE_CYCLES(4), .DWELL_CYCLES(8), .MIN_EYE(4)
   ) dut (
      .sysclk_i(sysclk), .rst_i(rst), .start_i(start), .chan_mask_i(chan_mask),
      .biterr_i(biterr), .data_i(data), .idelay_load_o(idelay_load),
      .idelay_value_o(idelay_value), .bitslip_o(bitslip), .busy_o(busy),
      .done_o(done), .fail_o(fail), .eye_center_o(eye_center), .eye_width_o(eye_width)
   );

   always #5 sysclk = ~sysclk;

   // Front-end model: per-channel clean-tap map and base word rotated left once per bitslip.
   logic [31:0] eye   [NCHAN];
   logic [DW-1:0] base [NCHAN];
   logic [TB-1:0] cur_tap  [NCHAN] = '{default: '0};
   int            slip_cnt [NCHAN] = '{default: 0};
   int            slip_base[NCHAN];

   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] w, input int n);
      logic [DW-1:0] r;
      r = w;
      for (int i = 0; i < (n % DW); i++) r = {r[DW-2:0], r[DW-1]};
      return r;
   endfunction

   for (genvar k = 0; k < NCHAN; k++) begin : g_fe
      assign biterr[k]          = ~eye[k][cur_tap[k]];
      assign data[k*DW +: DW]   = rotl(base[k], slip_cnt[k] - slip_base[k]);
   end

   always @(negedge sysclk) begin
      for (int k = 0; k < NCHAN; k++) begin
         if (idelay_load[k]) cur_tap[k]  <= idelay_value;
         if (bitslip[k])     slip_cnt[k] <= slip_cnt[k] + 1;
      end
   end

   int total = 0, passed = 0;
   int cyc = 0;
   int loads[NCHAN], slips[NCHAN], first_ld[NCHAN], last_ld[NCHAN];
   int dones, viol, last_slip, min_gap;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge sysclk);
      cyc++;
      for (int k = 0; k < NCHAN; k++) begin
         if (idelay_load[k]) begin
            loads[k]++;
            if (first_ld[k] < 0) first_ld[k] = cyc;
            last_ld[k] = cyc;
         end
         if (bitslip[k]) begin
            slips[k]++;
            if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
            last_slip = cyc;
         end
      end
      if (done) dones++;
      if ($countones(idelay_load) + $countones(bitslip) > 1) viol++;
   endtask

   task automatic clear_counts();
      for (int k = 0; k < NCHAN; k++) begin
         loads[k] = 0; slips[k] = 0; first_ld[k] = -1; last_ld[k] = -1;
         slip_base[k] = slip_cnt[k];
      end
      dones = 0; viol = 0; last_slip = -1; min_gap = 1000000;
   endtask

   task automatic pulse_start(input logic [NCHAN-1:0] m);
      chan_mask = m;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 5000) begin
         step();
         n++;
      end
      check({tag, "_done_seen"}, done, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      repeat (5) step();
   endtask

   task automatic run(input string tag, input logic [NCHAN-1:0] m);
      clear_counts();
      pulse_start(m);
      wait_done(tag);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; chan_mask = '0;
      for (int k = 0; k < NCHAN; k++) begin eye[k] = '0; base[k] = 4'h6; end
      clear_counts();
      repeat (3) step();
      check("rst_busy",   busy, 1'b0);
      check("rst_done",   done, 1'b0);
      check("rst_fail",   fail, '0);
      check("rst_center", eye_center, '0);
      check("rst_width",  eye_width, '0);
      rst = 1'b0;
      step();

      // 1: clean taps 10..25, word already aligned
      eye[0] = 32'h03FF_FC00; base[0] = 4'h6;
      run("t1", 3'b001);
      check("t1_width",  eye_width[0 +: 6], 6'd16);
      check("t1_center", eye_center[0 +: 5], 5'd18);
      check("t1_loads",  loads[0], 33);
      check("t1_final_tap", cur_tap[0], 5'd18);
      check("t1_slips",  slips[0], 0);
      check("t1_fail",   fail, 3'b000);
      check("t1_dones",  dones, 1);
      check("t1_others", {eye_center[5 +: 10], eye_width[6 +: 12]}, '0);

      // 2a: two equal windows 2..7 and 20..25, the first wins
      eye[0] = 32'h03F0_00FC;
      run("t2a", 3'b001);
      check("t2a_width",  eye_width[0 +: 6], 6'd6);
      check("t2a_center", eye_center[0 +: 5], 5'd5);
      check("t2a_fail",   fail, 3'b000);

      // 2b: errors everywhere
      eye[0] = 32'h0;
      run("t2b", 3'b001);
      check("t2b_fail",   fail, 3'b001);
      check("t2b_width",  eye_width[0 +: 6], 6'd0);
      check("t2b_loads",  loads[0], 32);
      check("t2b_slips",  slips[0], 0);

      // 3a: word aligns after three slips (0xC rotated left 3 = 0x6)
      eye[0] = 32'h03FF_FC00; base[0] = 4'hC;
      run("t3a", 3'b001);
      check("t3a_slips", slips[0], 3);
      check("t3a_gap",   min_gap >= 4, 1'b1);
      check("t3a_fail",  fail, 3'b000);

      // 3b: word never matches
      base[0] = 4'hF;
      run("t3b", 3'b001);
      check("t3b_slips", slips[0], 4);
      check("t3b_fail",  fail, 3'b001);
      check("t3b_width", eye_width[0 +: 6], 6'd16);

      // reset while idle clears result registers
      rst = 1'b1;
      step();
      check("rst2_fail",  fail, '0);
      check("rst2_width", eye_width, '0);
      rst = 1'b0;
      step();

      // 4: three channels, channel 1 masked off
      eye[0] = 32'h03FF_FC00; base[0] = 4'h6;
      eye[1] = 32'hFFFF_FFFF; base[1] = 4'h6;
      eye[2] = 32'h0000_003F; base[2] = 4'h6;
      run("t4", 3'b101);
      check("t4_loads0", loads[0], 33);
      check("t4_loads1", loads[1], 0);
      check("t4_loads2", loads[2], 33);
      check("t4_order",  first_ld[2] > last_ld[0], 1'b1);
      check("t4_slips",  slips[0] + slips[1] + slips[2], 0);
      check("t4_onehot", viol, 0);
      check("t4_center", eye_center, {5'd3, 5'd0, 5'd18});
      check("t4_width",  eye_width, {6'd6, 6'd0, 6'd16});
      check("t4_fail",   fail, 3'b000);

      // 5a: start while busy is ignored
      base[0] = 4'h6;
      clear_counts();
      pulse_start(3'b001);
      repeat (20) step();
      pulse_start(3'b111);
      wait_done("t5a");
      repeat (40) step();
      check("t5a_dones", dones, 1);
      check("t5a_loads", loads[0] + loads[1] + loads[2], 33);
      check("t5a_busy",  busy, 1'b0);

      // 5b: reset mid-DWELL aborts at once
      clear_counts();
      pulse_start(3'b001);
      repeat (9) step();
      check("t5b_busy_pre", busy, 1'b1);
      rst = 1'b1;
      step();
      check("t5b_outputs", {busy, done, fail, idelay_load, idelay_value, bitslip, eye_center, eye_width}, '0);
      repeat (3) step();
      rst = 1'b0;
      repeat (40) step();
      check("t5b_loads", loads[0], 1);
      check("t5b_dones", dones, 0);
      check("t5b_quiet", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
